// File: rtl/hit_conditioner.sv
`timescale 1ns/1ps
// hit_conditioner
// Turns the raw, bouncy hit button into a clean single-cycle hit strobe for
// the score stage. The raw input is synchronized by two flops and then
// debounced by an FSM. The FSM needs a stable run of samples to accept a
// press. It needs another stable run to accept the release. After the
// release it ignores the input for a short lockout window.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   btn_raw      raw asynchronous button, active-high, idle low
//   enable       when low, accepted presses give no hit_pulse and no count
//   hit_pulse    one-cycle strobe per accepted, enabled press
//   btn_level    debounced button level
//   press_count  accepted and enabled presses, wraps modulo 2^CNT_W
//   glitch_count aborted press attempts, saturates at all-ones
//   busy         high whenever the FSM is not in IDLE
module hit_conditioner #(
   parameter int DEBOUNCE_CYCLES = 10,
   parameter int LOCKOUT_CYCLES  = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_raw,
   input  logic             enable,
   output logic             hit_pulse,
   output logic             btn_level,
   output logic [CNT_W-1:0] press_count,
   output logic [CNT_W-1:0] glitch_count,
   output logic             busy
);

   // One counter serves both the debounce runs and the lockout window.
   localparam int MAX_CYC = (DEBOUNCE_CYCLES > LOCKOUT_CYCLES) ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LCK_LAST = CW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      PRESSED,
      RELEASE,
      LOCKOUT
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          ff1, ff2;
   logic          btn_s;
   logic          accept;
   logic          abort;

   // Two-flop synchronizer. Only btn_s is used past this point.
   // NOTE: sequential state uses non-blocking assignments, so that every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1 <= 1'b0;
         ff2 <= 1'b0;
      end else begin
         ff1 <= btn_raw;
         ff2 <= ff1;
      end
   end

   assign btn_s = ff2;

   // Next-state logic. In ARM and RELEASE, cnt counts the stable samples
   // already seen. When it reaches DEB_LAST, the current sample completes
   // the run.
   // NOTE: every signal gets a default before the case. Without the defaults,
   // a path that does not assign a signal would infer a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (btn_s) begin
               state_n = ARM;
               cnt_n   = '0;
            end
         end
         ARM: begin
            if (!btn_s) begin
               state_n = IDLE;
               abort   = 1'b1;
            end else if (cnt == DEB_LAST) begin
               state_n = PRESSED;
               accept  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_n = RELEASE;
               cnt_n   = '0;
            end
         end
         RELEASE: begin
            // A bounce back high resumes the press without a new strobe.
            if (btn_s) begin
               state_n = PRESSED;
            end else if (cnt == DEB_LAST) begin
               state_n = (LOCKOUT_CYCLES > 0) ? LOCKOUT : IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         LOCKOUT: begin
            // The input is ignored here. A press that is still held when
            // IDLE is re-entered starts a fresh ARM.
            if (cnt == LCK_LAST) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         hit_pulse    <= 1'b0;
         btn_level    <= 1'b0;
         press_count  <= '0;
         glitch_count <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hit_pulse <= accept & enable;
         // Driven from the next state so that the level moves on the same
         // edge as the state register.
         btn_level <= (state_n == PRESSED) || (state_n == RELEASE);
         if (accept && enable) begin
            press_count <= press_count + 1'b1;
         end
         if (abort && (glitch_count != '1)) begin
            glitch_count <= glitch_count + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_hit_conditioner.sv
`timescale 1ns/1ps
// Bench for hit_conditioner. Three instances share the same stimulus:
//   a: default parameters (10, 4, 8)
//   b: narrow counters (10, 4, 2), for the wrap and saturation boundaries
//   c: single-cycle debounce with no lockout (1, 0, 8)
// Each instance is compared every cycle against a run-length reference model.
module tb_hit_conditioner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       btn_raw = 1'b0;
   logic       enable = 1'b0;

   logic       hp_a, lvl_a, busy_a;
   logic [7:0] pc_a, gc_a;
   logic       hp_b, lvl_b, busy_b;
   logic [1:0] pc_b, gc_b;
   logic       hp_c, lvl_c, busy_c;
   logic [7:0] pc_c, gc_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hit_conditioner #(.DEBOUNCE_CYCLES(10), .LOCKOUT_CYCLES(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .enable(enable),
      .hit_pulse(hp_a), .btn_level(lvl_a), .press_count(pc_a),
      .glitch_count(gc_a), .busy(busy_a));

   hit_conditioner #(.DEBOUNCE_CYCLES(10), .LOCKOUT_CYCLES(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .enable(enable),
      .hit_pulse(hp_b), .btn_level(lvl_b), .press_count(pc_b),
      .glitch_count(gc_b), .busy(busy_b));

   hit_conditioner #(.DEBOUNCE_CYCLES(1), .LOCKOUT_CYCLES(0), .CNT_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .enable(enable),
      .hit_pulse(hp_c), .btn_level(lvl_c), .press_count(pc_c),
      .glitch_count(gc_c), .busy(busy_c));

   // Reference model. The button is seen through a two-sample delay.
   // A press is accepted after D+1 consecutive high samples, counted from
   // the first high sample seen while waiting. A release is accepted after
   // D+1 consecutive low samples while held. A release is followed by L
   // ignored samples.
   typedef enum int {WAITING, HELD, IGNORING} phase_t;

   typedef struct {
      int       d;
      int       l;
      int       cw;
      bit [1:0] dly;
      phase_t   phase;
      int       streak;
      int       ign;
      int       press;
      int       glitch;
      bit       pulse;
   } model_t;

   model_t ma, mb, mc;

   function automatic model_t model_init(input int d, input int l, input int cw);
      model_t m;
      m.d = d; m.l = l; m.cw = cw;
      m.dly = 2'b00; m.phase = WAITING; m.streak = 0; m.ign = 0;
      m.press = 0; m.glitch = 0; m.pulse = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(input model_t m, input bit raw, input bit en);
      bit s;
      s = m.dly[1];
      m.dly = {m.dly[0], raw};
      m.pulse = 1'b0;
      case (m.phase)
         WAITING: begin
            if (s) begin
               m.streak++;
               if (m.streak == m.d + 1) begin
                  m.phase = HELD;
                  m.streak = 0;
                  if (en) begin
                     m.pulse = 1'b1;
                     m.press = (m.press + 1) % (1 << m.cw);
                  end
               end
            end else if (m.streak > 0) begin
               m.streak = 0;
               if (m.glitch < (1 << m.cw) - 1) m.glitch++;
            end
         end
         HELD: begin
            if (!s) begin
               m.streak++;
               if (m.streak == m.d + 1) begin
                  m.streak = 0;
                  if (m.l > 0) begin
                     m.phase = IGNORING;
                     m.ign = m.l;
                  end else begin
                     m.phase = WAITING;
                  end
               end
            end else begin
               m.streak = 0;
            end
         end
         default: begin
            m.ign--;
            if (m.ign == 0) m.phase = WAITING;
         end
      endcase
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input string tag, input logic hp, input logic lvl, input logic bsy,
                          input logic [7:0] pc, input logic [7:0] gc, input model_t m);
      check({tag, ".hit_pulse"}, 32'(hp), 32'(m.pulse));
      check({tag, ".btn_level"}, 32'(lvl), 32'(m.phase == HELD));
      check({tag, ".busy"}, 32'(bsy), 32'((m.phase != WAITING) || (m.streak != 0)));
      check({tag, ".press_count"}, 32'(pc), m.press);
      check({tag, ".glitch_count"}, 32'(gc), m.glitch);
   endtask

   // One clock: advance the models on the edge and compare on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) begin
         ma = model_step(ma, btn_raw, enable);
         mb = model_step(mb, btn_raw, enable);
         mc = model_step(mc, btn_raw, enable);
      end
      @(negedge clk);
      cmp_dut("a", hp_a, lvl_a, busy_a, pc_a, gc_a, ma);
      cmp_dut("b", hp_b, lvl_b, busy_b, 8'(pc_b), 8'(gc_b), mb);
      cmp_dut("c", hp_c, lvl_c, busy_c, pc_c, gc_c, mc);
   endtask

   task automatic hold(input bit b, input bit e, input int n);
      btn_raw = b;
      enable = e;
      repeat (n) tick();
   endtask

   // Reset is asserted off the clock edge. The outputs must clear before any
   // clock edge arrives.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("rst.a.hit_pulse", 32'(hp_a), 0);
      check("rst.a.btn_level", 32'(lvl_a), 0);
      check("rst.a.busy", 32'(busy_a), 0);
      check("rst.a.press_count", 32'(pc_a), 0);
      check("rst.a.glitch_count", 32'(gc_a), 0);
      check("rst.b.busy", 32'(busy_b), 0);
      check("rst.b.press_count", 32'(pc_b), 0);
      check("rst.c.busy", 32'(busy_c), 0);
      check("rst.c.press_count", 32'(pc_c), 0);
      ma = model_init(10, 4, 8);
      mb = model_init(10, 4, 2);
      mc = model_init(1, 0, 8);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit btn;
      bit en;
      int cycles;
      int exp_pulses;
      int exp_first;   // tick of the first pulse within the segment, 0 = none
      int exp_press;
      int exp_glitch;
      bit exp_level;
      bit exp_busy;
   } vec_t;

   initial begin
      vec_t vecs[$];
      int   exp_w2[5];
      int   pulses;
      int   first;

      // Expected state of instance a at the end of each segment.
      vecs.push_back('{1, 1, 40, 1, 13, 1, 0, 1, 1});  // clean press, latency
      vecs.push_back('{0, 1, 40, 0,  0, 1, 0, 0, 0});  // release and lockout
      vecs.push_back('{1, 1,  5, 0,  0, 1, 0, 0, 1});  // short press, in ARM
      vecs.push_back('{0, 1, 20, 0,  0, 1, 1, 0, 0});  // counted as a glitch
      vecs.push_back('{1, 1, 20, 1, 13, 2, 1, 1, 1});  // clean press
      vecs.push_back('{0, 1,  3, 0,  0, 2, 1, 1, 1});  // low bounce while held
      vecs.push_back('{1, 1, 30, 0,  0, 2, 1, 1, 1});  // back high, no new pulse
      vecs.push_back('{0, 1, 40, 0,  0, 2, 1, 0, 0});
      vecs.push_back('{1, 0, 20, 0,  0, 2, 1, 1, 1});  // disabled press
      vecs.push_back('{0, 0, 40, 0,  0, 2, 1, 0, 0});
      vecs.push_back('{1, 1, 20, 1, 13, 3, 1, 1, 1});  // enabled again
      vecs.push_back('{0, 1, 13, 0,  0, 3, 1, 0, 1});  // release accepted, LOCKOUT
      vecs.push_back('{1, 1, 30, 1, 15, 4, 1, 1, 1});  // press during lockout
      vecs.push_back('{0, 1, 40, 0,  0, 4, 1, 0, 0});

      #2;
      apply_reset();

      foreach (vecs[i]) begin
         btn_raw = vecs[i].btn;
         enable  = vecs[i].en;
         pulses  = 0;
         first   = 0;
         for (int t = 1; t <= vecs[i].cycles; t++) begin
            tick();
            if (hp_a === 1'b1) begin
               pulses++;
               if (first == 0) first = t;
            end
         end
         check($sformatf("vec%0d.pulses", i), pulses, vecs[i].exp_pulses);
         check($sformatf("vec%0d.first_pulse", i), first, vecs[i].exp_first);
         check($sformatf("vec%0d.press_count", i), 32'(pc_a), vecs[i].exp_press);
         check($sformatf("vec%0d.glitch_count", i), 32'(gc_a), vecs[i].exp_glitch);
         check($sformatf("vec%0d.btn_level", i), 32'(lvl_a), 32'(vecs[i].exp_level));
         check($sformatf("vec%0d.busy", i), 32'(busy_a), 32'(vecs[i].exp_busy));
      end

      // Boundaries of the narrow counters: press_count wraps, glitch_count saturates.
      apply_reset();
      exp_w2 = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
         hold(1'b1, 1'b1, 20);
         hold(1'b0, 1'b1, 20);
         check($sformatf("w2.press_count[%0d]", i), 32'(pc_b), exp_w2[i]);
      end
      for (int i = 0; i < 5; i++) begin
         hold(1'b1, 1'b1, 3);
         hold(1'b0, 1'b1, 10);
      end
      check("w2.glitch_sat", 32'(gc_b), 3);
      check("a.glitch_after_5", 32'(gc_a), 5);

      // Reset in the middle of ARM, with the button held through the reset.
      hold(1'b0, 1'b1, 5);
      hold(1'b1, 1'b1, 9);              // ARM with cnt=6 after the 9th edge
      check("pre_reset.busy", 32'(busy_a), 1);
      #2;
      apply_reset();
      first = 0;
      for (int t = 1; t <= 40 && first == 0; t++) begin
         tick();
         if (hp_a === 1'b1) first = t;
      end
      check("post_reset.pulse_tick", first, 13);
      check("post_reset.press_count", 32'(pc_a), 1);
      hold(1'b0, 1'b1, 40);

      // Random run lengths, including very short bounces.
      for (int seg = 0; seg < 80; seg++) begin
         btn_raw = ~btn_raw;
         enable  = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 30)) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
